// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM-state and memory-arbiter state types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, IGNT, DGNT} memarb_state_t;
endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick: combinational grant selection between fetch and data sources.
module mem_arbiter_pick
  import cpu_types_pkg::*;
(
  input  logic          iren,
  input  logic          dreq,
  input  logic          last_d,
  input  memarb_state_t state,
  output logic          grant_i,
  output logic          grant_d
);
  // Data wins ties unless it completed last, so fetches never starve.
  always_comb begin
    grant_d = (state == DGNT) ? dreq : (state == IDLE) ? dreq & ~(iren & last_d) : 1'b0;
    grant_i = (state == IGNT) ? iren : (state == IDLE) ? iren & ~grant_d : 1'b0;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: multiplexes icache and dcache requests onto one RAM port.
// Optional grant watchdog with sticky arb_err enabled by MEMARB_TIMEOUT_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);
  memarb_state_t state, state_n;
  logic last_d, last_d_n, grant_i, grant_d, gi, gd, acc, tmo, dreq;

  if (2**CNT_W <= TIMEOUT) begin : g_cnt_w_chk
    $error("CNT_W too narrow for TIMEOUT");
  end

  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  mem_arbiter_pick u_pick (
    .iren    (iREN),
    .dreq    (dreq),
    .last_d  (last_d),
    .state   (state),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

`ifdef MEMARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  assign tmo = (state != IDLE) && (cnt == CNT_W'(TIMEOUT));
  // The arbitration cycle in IDLE counts as the first waiting cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt     <= '0;
      arb_err <= 1'b0;
    end else begin
      cnt     <= (state == IDLE) ? CNT_W'(1) : cnt + 1'b1;
      arb_err <= arb_err | tmo;
    end
  end
`else
  assign tmo     = 1'b0;
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_n;
      last_d <= last_d_n;
    end
  end

  // Grants are masked during reset so nothing reaches the RAM.
  always_comb begin
    gi       = grant_i & nRST & ~tmo;
    gd       = grant_d & nRST & ~tmo;
    acc      = ramstate == ACCESS;
    ramREN   = gi | (gd & ~dWEN);
    ramWEN   = gd & dWEN;
    ramaddr  = gd ? daddr : gi ? iaddr : '0;
    ramstore = gd ? dstore : '0;
    iwait    = ~(gi & acc);
    dwait    = ~(gd & acc);
    state_n  = IDLE;
    last_d_n = last_d;
    if (gi | gd) begin
      if (acc) last_d_n = gd;
      else     state_n  = gd ? DGNT : IGNT;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0, nRST = 1'b0;
  logic iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, arb_err;
  word_t iaddr, daddr, dstore, iload, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic [67:0] exp;
  int n_assert = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  function automatic logic [67:0] obs();
    return {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ir, input word_t ia, input logic dr, input logic dw,
                       input word_t da, input word_t ds, input ramstate_t rs);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds; ramstate = rs;
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    ramload = 32'hA5A5A5A5;
    drive(1, 32'h10, 1, 1, 32'h20, 32'h30, ACCESS);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL reset_out: got %h want %h", obs(), exp); end
    n_assert++; if ({iload, dload} !== {2{32'hA5A5A5A5}}) begin n_fail++; $display("FAIL reset_load: got %h/%h want a5a5a5a5", iload, dload); end
    n_assert++; if (arb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", arb_err); end
    step();
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL reset_held: got %h want %h", obs(), exp); end
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, FREE);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL idle_out: got %h want %h", obs(), exp); end
  endtask

  task automatic test_ifetch();
    drive(1, 32'h100, 0, 0, 0, 0, BUSY);
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL ifetch_c1: got %h want %h", obs(), exp); end
    step();
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL ifetch_c2: got %h want %h", obs(), exp); end
    step();
    ramload = 32'hDEADBEEF;
    drive(1, 32'h100, 0, 0, 0, 0, ACCESS);
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL ifetch_c3: got %h want %h", obs(), exp); end
    n_assert++; if (iload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ifetch_load: got %h want deadbeef", iload); end
    step();
    drive(0, 0, 0, 0, 0, 0, FREE);
  endtask

  task automatic test_contention();
    drive(1, 32'h104, 0, 1, 32'h200, 32'h1234, BUSY);
    exp = {1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h1234};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL cont_data_first: got %h want %h", obs(), exp); end
    step();
    drive(1, 32'h104, 0, 1, 32'h200, 32'h1234, ACCESS);
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h1234};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL cont_data_done: got %h want %h", obs(), exp); end
    step();
    drive(1, 32'h104, 0, 0, 0, 0, BUSY);
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL cont_fetch_next: got %h want %h", obs(), exp); end
    step();
    drive(1, 32'h104, 0, 0, 0, 0, ACCESS);
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL cont_fetch_done: got %h want %h", obs(), exp); end
    step();
    drive(0, 0, 0, 0, 0, 0, FREE);
  endtask

  task automatic test_write_precedence();
    drive(0, 0, 1, 1, 32'h210, 32'h55, ACCESS);
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 32'h210, 32'h55};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL wr_over_rd: got %h want %h", obs(), exp); end
    step();
    drive(0, 0, 0, 0, 0, 0, FREE);
  endtask

  // Data completed last, so the fetch must win first and the two then alternate.
  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h300, 1, 0, 32'h600, 32'h0, ACCESS);
      exp = (k % 2 == 0) ? {1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0}
                         : {1'b1, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0};
      n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL b2b_%0d: got %h want %h", k, obs(), exp); end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, FREE);
  endtask

  task automatic test_no_preempt();
    drive(0, 0, 1, 0, 32'h400, 32'h0, BUSY);
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL nopre_grant: got %h want %h", obs(), exp); end
    step();
    drive(1, 32'h108, 1, 0, 32'h400, 32'h0, BUSY);
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL nopre_hold: got %h want %h", obs(), exp); end
    step();
    drive(1, 32'h108, 1, 0, 32'h400, 32'h0, ERROR);
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL nopre_error: got %h want %h", obs(), exp); end
    step();
    drive(1, 32'h108, 1, 0, 32'h400, 32'h0, ACCESS);
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL nopre_ddone: got %h want %h", obs(), exp); end
    step();
    drive(1, 32'h108, 0, 0, 0, 0, BUSY);
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 32'h108, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL nopre_fetch: got %h want %h", obs(), exp); end
    step();
    drive(1, 32'h108, 0, 0, 0, 0, ACCESS);
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 32'h108, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL nopre_fdone: got %h want %h", obs(), exp); end
    step();
    drive(0, 0, 0, 0, 0, 0, FREE);
  endtask

  task automatic test_drop();
    drive(0, 0, 1, 0, 32'h500, 32'h0, ACCESS);
    step();
    drive(0, 0, 1, 0, 32'h500, 32'h0, BUSY);
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL drop_grant: got %h want %h", obs(), exp); end
    step();
    drive(0, 0, 0, 0, 32'h500, 32'h0, ACCESS);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL drop_strobes: got %h want %h", obs(), exp); end
    step();
    drive(1, 32'h10C, 1, 0, 32'h500, 32'h0, ACCESS);
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL drop_ldkeep: got %h want %h", obs(), exp); end
    step();
    drive(0, 0, 0, 0, 0, 0, FREE);
  endtask

  task automatic test_mid_reset();
    drive(0, 0, 1, 0, 32'h700, 32'h0, ACCESS);
    step();
    drive(1, 32'h110, 0, 0, 0, 0, BUSY);
    step();
    ramstate = ACCESS;
    nRST = 1'b0;
    #1;
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL midrst_out: got %h want %h", obs(), exp); end
    step();
    nRST = 1'b1;
    drive(1, 32'h110, 1, 0, 32'h700, 32'h0, ACCESS);
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 32'h700, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL midrst_ldclr: got %h want %h", obs(), exp); end
    step();
    drive(0, 0, 0, 0, 0, 0, FREE);
  endtask

`ifdef MEMARB_TIMEOUT_EN
  task automatic test_timeout();
    drive(0, 0, 1, 0, 32'h800, 32'h0, BUSY);
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 32'h800, 32'h0};
    for (int c = 1; c <= 8; c++) begin
      n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL tmo_wait_%0d: got %h want %h", c, obs(), exp); end
      step();
    end
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL tmo_drop: got %h want %h", obs(), exp); end
    step();
    drive(0, 0, 1, 0, 32'h800, 32'h0, ACCESS);
    exp = {1'b1, 1'b0, 1'b1, 1'b0, 32'h800, 32'h0};
    n_assert++; if (obs() !== exp) begin n_fail++; $display("FAIL tmo_retry: got %h want %h", obs(), exp); end
    n_assert++; if (arb_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", arb_err); end
    step();
    drive(0, 0, 0, 0, 0, 0, FREE);
    step();
    n_assert++; if (arb_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", arb_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_ifetch();
    test_contention();
    test_write_precedence();
    test_back_to_back();
    test_no_preempt();
    test_drop();
    test_mid_reset();
`ifdef MEMARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
